ifetch: RTL and testbench
=========================

# ifetch

Instruction fetch unit for the Forth CPU: the consumer of the next-IP value produced by the core's IP-select logic. It holds the fetch pointer and issues single-outstanding read requests to instruction memory over a req/ack handshake. Returned words are buffered in a small prefetch FIFO together with their addresses and handed to decode over a valid/ready interface. A redirect (branch, call, return, skip) reloads the fetch pointer, flushes the FIFO and discards any in-flight response.

## Interface
- iaddr_width, 10, instruction address width
- insn_width, 16, instruction word width
- depth, 2, prefetch FIFO entries (power of two, ≥1)
- reset_addr, 0, fetch pointer value after reset
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- redirect  in  1  load redirect_addr as new fetch pointer, flush FIFO
- redirect_addr  in  iaddr_width  new fetch address (driven from the next-IP result)
- mem_req  out  1  read request to instruction memory
- mem_addr  out  iaddr_width  request address; stable while mem_req high
- mem_ack  in  1  request accepted, mem_rdata valid this cycle
- mem_rdata  in  insn_width  read data
- insn_valid  out  1  FIFO head valid
- insn  out  insn_width  FIFO head instruction
- insn_addr  out  iaddr_width  address of insn (IP of the instruction)
- insn_ready  in  1  decode accepts head this cycle

## Operation
- Registers: fetch_addr, state ∈ {IDLE, REQ, DROP}, FIFO (addr, insn), count 0..depth.
- mem_req = (state != IDLE); mem_addr = fetch_addr. mem_ack ignored in IDLE.
- pop = insn_valid & insn_ready; insn_valid = (count != 0).
- IDLE: if (count − pop) < depth → REQ.
- REQ, mem_ack, no redirect: push {fetch_addr, mem_rdata}; fetch_addr += 1 (mod 2^iaddr_width); stay REQ if (count + 1 − pop) < depth, else IDLE.
- REQ, no mem_ack: hold mem_req and mem_addr unchanged (no retraction).
- redirect (any state): fetch_addr ← redirect_addr; count ← 0; a pop in the same cycle still counts as consumed.
  - IDLE, or REQ with mem_ack: → REQ (response discarded).
  - REQ without mem_ack: → DROP; mem_addr remains the old address until ack.
  - DROP: stay DROP; fetch_addr updated.
- DROP, mem_ack, no redirect: discard data, → REQ at new fetch_addr.
- FIFO never overflows: the request condition reserves space for the single outstanding response.
- Reset: fetch_addr = reset_addr, state = IDLE, count = 0, mem_req = 0, insn_valid = 0; insn and insn_addr don't-care while insn_valid = 0.
- Reset mid-request abandons the transaction; memory must tolerate mem_req dropping on reset only.

## Timing
- First cycle after rst deasserts: IDLE, mem_req = 0. Next cycle: mem_req = 1, mem_addr = reset_addr.
- mem_ack at cycle M with no redirect → insn_valid at M+1 (registered FIFO).
- Zero-wait memory (ack same cycle as req) with decode always ready: one instruction per cycle sustained.
- Redirect at cycle N with no outstanding request → mem_req with redirect_addr at N+1. Outstanding request → new address one cycle after its ack.
- insn_valid falls in the cycle after redirect.

## Structure
- Shared package/include: state encoding (IDLE, REQ, DROP); default widths matching the core's iaddr_width/insn_width.
- Sub-module ifetch_fifo: synchronous FIFO with parameterised depth and data width iaddr_width+insn_width, with push, pop, flush, count. Flush has priority over push.
- Top level holds the FSM and fetch pointer only.

## Test plan
- Reset, reset_addr=0x3F0, ack every request, insn_ready=1 → mem_addr 0x3F0, 0x3F1, …; insn_addr follows one cycle later; one instruction per cycle.
- insn_ready=0, depth=2 → exactly two acks accepted, then mem_req=0. insn_ready=1 for one cycle → one new request.
- Redirect to 0x100 while a request to 0x050 waits for ack (ack after 3 cycles) → mem_addr stays 0x050 until ack, data dropped, next mem_addr=0x100, insn_valid stays 0 until 0x100's data returns.
- Redirect in the same cycle as mem_ack and pop → FIFO empty next cycle, returned word never appears, mem_addr=redirect_addr next cycle.
- Fetch at 0x3FF (iaddr_width=10) → next mem_addr 0x000.
- Assert rst for one cycle while mem_req=1 → all outputs at reset values; fetch restarts at reset_addr.

Source files
------------

// File: rtl/ifetch_pkg.sv
// Shared definitions for the instruction fetch unit: default widths matching
// the core, and the fetch FSM state encoding.
package ifetch_pkg;

  localparam int unsigned IADDR_WIDTH = 10;
  localparam int unsigned INSN_WIDTH  = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DROP = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/ifetch_fifo.sv
// Prefetch FIFO holding {address, instruction} pairs between memory and decode.
// Flush wins over push; count runs 0..depth.
module ifetch_fifo #(
  parameter int unsigned depth = 2,
  parameter int unsigned width = 26
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  input  logic                         push,
  input  logic                         pop,
  input  logic [width-1:0]             din,
  output logic [width-1:0]             dout,
  output logic [$clog2(depth+1)-1:0]   count
);

  localparam int unsigned aw = (depth > 1) ? $clog2(depth) : 1;
  localparam logic [aw-1:0] last_idx = aw'(depth - 1);

  logic [width-1:0] mem [depth];
  logic [aw-1:0]    wr_ptr;
  logic [aw-1:0]    rd_ptr;

  function automatic logic [aw-1:0] next_ptr(input logic [aw-1:0] p);
    return (p == last_idx) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= next_ptr(wr_ptr);
      if (pop)  rd_ptr <= next_ptr(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign dout = mem[rd_ptr];

endmodule

// File: rtl/ifetch.sv
// Instruction fetch: fetch pointer and single-outstanding request FSM feeding
// the prefetch FIFO; redirects reload the pointer and flush buffered words.
module ifetch
  import ifetch_pkg::*;
#(
  parameter int unsigned             iaddr_width = IADDR_WIDTH,
  parameter int unsigned             insn_width  = INSN_WIDTH,
  parameter int unsigned             depth       = 2,
  parameter logic [iaddr_width-1:0]  reset_addr  = '0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   redirect,
  input  logic [iaddr_width-1:0] redirect_addr,
  output logic                   mem_req,
  output logic [iaddr_width-1:0] mem_addr,
  input  logic                   mem_ack,
  input  logic [insn_width-1:0]  mem_rdata,
  output logic                   insn_valid,
  output logic [insn_width-1:0]  insn,
  output logic [iaddr_width-1:0] insn_addr,
  input  logic                   insn_ready
);

  localparam int unsigned cw = $clog2(depth + 1);
  localparam logic [cw:0] depth_lvl = (cw + 1)'(depth);

  fetch_state_t           state, state_next;
  logic [iaddr_width-1:0] fetch_addr, fetch_addr_next;
  logic [iaddr_width-1:0] drop_addr;
  logic [cw-1:0]          count;
  logic [cw:0]            level;
  logic                   push, pop, flush;
  logic                   room_idle, room_ack;

  assign pop        = insn_valid & insn_ready;
  assign flush      = redirect;
  assign insn_valid = (count != '0);
  assign mem_req    = (state != IDLE);

  // fetch_addr moves to the redirect target immediately, but the abandoned
  // request must keep presenting its original address until it is acked.
  assign mem_addr   = (state == DROP) ? drop_addr : fetch_addr;

  // Occupancy after this cycle's pop; a new request is only issued when the
  // response it will produce is guaranteed a free slot.
  assign level     = {1'b0, count} - {{cw{1'b0}}, pop};
  assign room_idle = (level < depth_lvl);
  assign room_ack  = ((level + 1'b1) < depth_lvl);

  always_comb begin
    state_next      = state;
    fetch_addr_next = fetch_addr;
    push            = 1'b0;
    case (state)
      IDLE: begin
        if (redirect || room_idle) state_next = REQ;
      end
      REQ: begin
        if (redirect) begin
          state_next = mem_ack ? REQ : DROP;
        end else if (mem_ack) begin
          push            = 1'b1;
          fetch_addr_next = fetch_addr + 1'b1;
          state_next      = room_ack ? REQ : IDLE;
        end
      end
      DROP: begin
        if (!redirect && mem_ack) state_next = REQ;
      end
      default: state_next = IDLE;
    endcase
    if (redirect) fetch_addr_next = redirect_addr;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      fetch_addr <= reset_addr;
      drop_addr  <= reset_addr;
    end else begin
      state      <= state_next;
      fetch_addr <= fetch_addr_next;
      if (state == REQ && state_next == DROP) drop_addr <= fetch_addr;
    end
  end

  ifetch_fifo #(
    .depth (depth),
    .width (iaddr_width + insn_width)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .push  (push),
    .pop   (pop),
    .din   ({fetch_addr, mem_rdata}),
    .dout  ({insn_addr, insn}),
    .count (count)
  );

endmodule

// File: tb/tb_ifetch.sv
// Bench for ifetch: scoreboarded streaming fetch with address wrap, a cycle
// table for backpressure and redirect corners, and a mid-request reset.
module tb_ifetch;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        redirect = 1'b0;
  logic [9:0]  redirect_addr = '0;
  logic        mem_req;
  logic [9:0]  mem_addr;
  logic        mem_ack = 1'b0;
  logic [15:0] mem_rdata;
  logic        insn_valid;
  logic [15:0] insn;
  logic [9:0]  insn_addr;
  logic        insn_ready = 1'b0;

  int unsigned nvec  = 0;
  int unsigned nfail = 0;

  typedef struct {
    logic [9:0]  a;
    logic [15:0] d;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    logic       rd;
    logic [9:0] ra;
    logic       ack;
    logic       rdy;
    logic       req;
    logic [9:0] addr;
    logic       valid;
    logic [9:0] iaddr;
  } vec_t;
  vec_t tbl[17];

  always #5 clk = ~clk;

  ifetch #(
    .iaddr_width (10),
    .insn_width  (16),
    .depth       (2),
    .reset_addr  (10'h3F0)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .redirect      (redirect),
    .redirect_addr (redirect_addr),
    .mem_req       (mem_req),
    .mem_addr      (mem_addr),
    .mem_ack       (mem_ack),
    .mem_rdata     (mem_rdata),
    .insn_valid    (insn_valid),
    .insn          (insn),
    .insn_addr     (insn_addr),
    .insn_ready    (insn_ready)
  );

  function automatic logic [15:0] insn_of(input logic [9:0] a);
    return {a[3:0] ^ 4'hA, 2'b01, a};
  endfunction

  // Memory model: word content is a fixed function of the address.
  assign mem_rdata = insn_of(mem_addr);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input logic rd, input logic [9:0] ra, input logic ack, input logic rdy);
    redirect      = rd;
    redirect_addr = ra;
    mem_ack       = ack;
    insn_ready    = rdy;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    redirect = 1'b0; mem_ack = 1'b0; insn_ready = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("reset_req", mem_req, 0);
    chk("reset_valid", insn_valid, 0);
  endtask

  function automatic vec_t mk(input logic rd, input logic [9:0] ra, input logic ack,
                              input logic rdy, input logic req, input logic [9:0] addr,
                              input logic valid, input logic [9:0] iaddr);
    vec_t v;
    v.rd = rd; v.ra = ra; v.ack = ack; v.rdy = rdy;
    v.req = req; v.addr = addr; v.valid = valid; v.iaddr = iaddr;
    return v;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    exp_t e;
    logic [9:0] ea;

    // Inputs for a row drive the cycle whose start-of-cycle outputs it expects.
    tbl[0]  = mk(0, 10'h000, 0, 0, 0, 10'h000, 0, 10'h000);
    tbl[1]  = mk(0, 10'h000, 1, 0, 1, 10'h3F0, 0, 10'h000);
    tbl[2]  = mk(0, 10'h000, 1, 0, 1, 10'h3F1, 1, 10'h3F0);
    tbl[3]  = mk(0, 10'h000, 1, 0, 0, 10'h000, 1, 10'h3F0);
    tbl[4]  = mk(0, 10'h000, 0, 1, 0, 10'h000, 1, 10'h3F0);
    tbl[5]  = mk(0, 10'h000, 0, 0, 1, 10'h3F2, 1, 10'h3F1);
    tbl[6]  = mk(1, 10'h050, 0, 0, 1, 10'h3F2, 1, 10'h3F1);
    tbl[7]  = mk(0, 10'h000, 1, 0, 1, 10'h3F2, 0, 10'h000);
    tbl[8]  = mk(0, 10'h000, 0, 0, 1, 10'h050, 0, 10'h000);
    tbl[9]  = mk(1, 10'h100, 0, 0, 1, 10'h050, 0, 10'h000);
    tbl[10] = mk(0, 10'h000, 0, 0, 1, 10'h050, 0, 10'h000);
    tbl[11] = mk(0, 10'h000, 1, 0, 1, 10'h050, 0, 10'h000);
    tbl[12] = mk(0, 10'h000, 1, 1, 1, 10'h100, 0, 10'h000);
    tbl[13] = mk(1, 10'h200, 1, 1, 1, 10'h101, 1, 10'h100);
    tbl[14] = mk(0, 10'h000, 0, 1, 1, 10'h200, 0, 10'h000);
    tbl[15] = mk(0, 10'h000, 1, 0, 1, 10'h200, 0, 10'h000);
    tbl[16] = mk(0, 10'h000, 0, 0, 1, 10'h201, 1, 10'h200);

    // Streaming from reset_addr with zero-wait memory, crossing 0x3FF -> 0x000.
    do_reset();
    step(0, '0, 0, 0);
    for (int i = 0; i < 18; i++) begin
      ea = 10'h3F0 + 10'(i);
      chk("stream_req", mem_req, 1);
      chk("stream_addr", mem_addr, ea);
      chk("stream_valid", insn_valid, (i > 0) ? 1 : 0);
      if (insn_valid) begin
        if (sb.size() == 0) begin
          chk("stream_sb_nonempty", 0, 1);
        end else begin
          e = sb.pop_front();
          chk("stream_insn_addr", insn_addr, e.a);
          chk("stream_insn", insn, e.d);
        end
      end
      sb.push_back('{a: ea, d: insn_of(ea)});
      step(0, '0, 1, 1);
    end
    chk("drain_valid", insn_valid, 1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk("drain_insn_addr", insn_addr, e.a);
      chk("drain_insn", insn, e.d);
    end
    step(0, '0, 0, 1);
    chk("drain_empty", insn_valid, 0);
    chk("drain_sb_empty", sb.size(), 0);

    // Backpressure, redirect during a pending request, redirect with ack+pop.
    do_reset();
    foreach (tbl[i]) begin
      chk($sformatf("t%0d_req", i), mem_req, tbl[i].req);
      if (tbl[i].req) chk($sformatf("t%0d_addr", i), mem_addr, tbl[i].addr);
      chk($sformatf("t%0d_valid", i), insn_valid, tbl[i].valid);
      if (tbl[i].valid) begin
        chk($sformatf("t%0d_iaddr", i), insn_addr, tbl[i].iaddr);
        chk($sformatf("t%0d_insn", i), insn, insn_of(tbl[i].iaddr));
      end
      step(tbl[i].rd, tbl[i].ra, tbl[i].ack, tbl[i].rdy);
    end

    // Asynchronous reset while a request is outstanding and the FIFO holds data.
    chk("prerst_req", mem_req, 1);
    chk("prerst_valid", insn_valid, 1);
    #2 rst = 1'b1;
    #1;
    chk("rst_async_req", mem_req, 0);
    chk("rst_async_valid", insn_valid, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_post_req", mem_req, 0);
    step(0, '0, 0, 0);
    chk("rst_restart_req", mem_req, 1);
    chk("rst_restart_addr", mem_addr, 10'h3F0);
    chk("rst_restart_valid", insn_valid, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
